// File: rtl/flap_body.sv
// flap_body: vertical physics and life-cycle state of the player body.
// The body waits in READY, flies under gravity with flap impulses in FLY,
// and freezes in DEAD until a new flap returns it to READY.
module flap_body #(
  parameter int W            = 12,
  parameter int H_SIZE       = 8,
  parameter int IX           = 320,
  parameter int IY           = 240,
  parameter int D_HEIGHT     = 480,
  parameter int FLOOR_MARGIN = 30,
  parameter int GRAV         = 1,
  parameter int FLAP_VEL     = 10,
  parameter int VMAX         = 12,
  parameter int COOLDOWN     = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_physics_stb,
  input  logic         i_flap,
  input  logic         i_hit,
  output logic [W-1:0] o_x1,
  output logic [W-1:0] o_x2,
  output logic [W-1:0] o_y1,
  output logic [W-1:0] o_y2,
  output logic [W-1:0] o_vel,
  output logic [1:0]   o_state,
  output logic         o_dead
);

  localparam int FLOOR_Y = D_HEIGHT - FLOOR_MARGIN - H_SIZE;
  localparam int CW      = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  // Wide signed constants for comparing against the W+1-bit intermediates.
  localparam logic signed [W:0]   CEIL_S  = (W+1)'(H_SIZE);
  localparam logic signed [W:0]   FLOOR_S = (W+1)'(FLOOR_Y);
  localparam logic signed [W:0]   VMAX_S  = (W+1)'(VMAX);
  localparam logic signed [W:0]   GRAV_S  = (W+1)'(GRAV);
  localparam logic signed [W-1:0] FLAP_V  = W'(-FLAP_VEL);
  localparam logic [CW-1:0]       CD_INIT = CW'(COOLDOWN);

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_FLY   = 2'b01,
    ST_DEAD  = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          y_q, y_d;
  logic signed [W-1:0]   vel_q, vel_d;
  logic [CW-1:0]         cd_q, cd_d;
  logic                  flap_prev_q, flap_prev_d;

  logic                  flap_ev;
  logic signed [W:0]     y_sum;
  logic signed [W:0]     vel_grav;
  logic signed [W-1:0]   vel_sat;

  // Rising edge of the button against last cycle's sample.
  assign flap_ev = i_flap & ~flap_prev_q;

  // Position integration and gravity, one bit wider so that overshoot above
  // the top of the screen shows up as a negative value rather than wrapping.
  assign y_sum    = $signed({1'b0, y_q}) + $signed({vel_q[W-1], vel_q});
  assign vel_grav = $signed({vel_q[W-1], vel_q}) + GRAV_S;
  assign vel_sat  = (vel_grav > VMAX_S) ? VMAX_S[W-1:0] : vel_grav[W-1:0];

  // Next-state logic for the life-cycle FSM and the physics registers.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    vel_d       = vel_q;
    cd_d        = cd_q;
    flap_prev_d = i_flap;
    case (state_q)
      ST_READY: begin
        y_d   = W'(IY);
        vel_d = '0;
        if (flap_ev) begin
          state_d = ST_FLY;
          vel_d   = FLAP_V;
          cd_d    = CD_INIT;
        end
      end
      ST_FLY: begin
        if (i_hit) begin
          // Collision beats any flap in the same cycle; position freezes.
          state_d = ST_DEAD;
          vel_d   = '0;
        end else begin
          if (i_physics_stb) begin
            y_d   = y_sum[W-1:0];
            vel_d = vel_sat;
            if (cd_q != '0) cd_d = cd_q - CW'(1);
          end
          // An accepted flap replaces the gravity step but y still moved
          // by the old velocity above.
          if (flap_ev && (cd_q == '0)) begin
            vel_d = FLAP_V;
            cd_d  = CD_INIT;
          end
          if (i_physics_stb) begin
            if (y_sum < CEIL_S) begin
              y_d   = W'(H_SIZE);
              vel_d = '0;
            end else if (y_sum >= FLOOR_S) begin
              y_d     = W'(FLOOR_Y);
              vel_d   = '0;
              state_d = ST_DEAD;
            end
          end
        end
      end
      ST_DEAD: begin
        if (flap_ev) begin
          state_d = ST_READY;
          y_d     = W'(IY);
          vel_d   = '0;
          cd_d    = '0;
        end
      end
      default: begin
        state_d = ST_READY;
        y_d     = W'(IY);
        vel_d   = '0;
        cd_d    = '0;
      end
    endcase
  end

  // State registers; the previous-flap sample resets high so a button held
  // through reset must be released before it can start a flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_READY;
      y_q         <= W'(IY);
      vel_q       <= '0;
      cd_q        <= '0;
      flap_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      vel_q       <= vel_d;
      cd_q        <= cd_d;
      flap_prev_q <= flap_prev_d;
    end
  end

  assign o_x1    = W'(IX - H_SIZE);
  assign o_x2    = W'(IX + H_SIZE);
  assign o_y1    = y_q - W'(H_SIZE);
  assign o_y2    = y_q + W'(H_SIZE);
  assign o_vel   = vel_q;
  assign o_state = state_q;
  assign o_dead  = (state_q == ST_DEAD);

endmodule

// File: doc/flap_body.md
FLAP_BODY -- requirements
Module: flap_body

Interface
REQ-001 Parameter W, default 12, coordinate/velocity width in bits.
REQ-002 Parameter H_SIZE, default 8, half body size in pixels.
REQ-003 Parameter IX, default 320; IY, default 240; initial centre position.
REQ-004 Parameter D_HEIGHT, default 480, display height; FLOOR_MARGIN, default 30, ground strip height.
REQ-005 Parameter GRAV, default 1, velocity increment per physics tick.
REQ-006 Parameter FLAP_VEL, default 10, upward speed magnitude applied by a flap.
REQ-007 Parameter VMAX, default 12, terminal downward velocity.
REQ-008 Parameter COOLDOWN, default 4, physics ticks during which further flaps are ignored.
REQ-009 i_clk  input  1  system clock.
REQ-010 i_rst  input  1  reset: synchronous, active-high.
REQ-011 i_physics_stb  input  1  one-cycle physics tick.
REQ-012 i_flap  input  1  flap button level, synchronous to i_clk.
REQ-013 i_hit  input  1  obstacle collision flag from pipe logic.
REQ-014 o_x1, o_x2, o_y1, o_y2  output  W each  body left/right/top/bottom edges (centre -/+ H_SIZE).
REQ-015 o_vel  output  W  signed vertical velocity, positive = down.
REQ-016 o_state  output  2  READY=00, FLY=01, DEAD=10.
REQ-017 o_dead  output  1  high exactly when state is DEAD.

Function
REQ-018 Flap event SHALL be the rising edge of i_flap, detected against a registered previous sample.
REQ-019 READY: y held at IY, vel 0; flap event -> FLY next cycle with vel=-FLAP_VEL, cooldown=COOLDOWN.
REQ-020 FLY, on i_physics_stb: y_next = y + vel (signed, W+1-bit intermediate); vel_next = min(vel+GRAV, VMAX).
REQ-021 FLY flap event with cooldown==0 SHALL set vel=-FLAP_VEL and cooldown=COOLDOWN, overriding the gravity update of vel in that cycle; y still integrates the old vel if a tick coincides.
REQ-022 Flap event with cooldown>0 SHALL be discarded, not queued.
REQ-023 Cooldown SHALL decrement by 1 per physics tick, saturating at 0.
REQ-024 Ceiling: if y_next < H_SIZE (including negative), y=H_SIZE and vel=0; state stays FLY.
REQ-025 Floor: with FLOOR_Y = D_HEIGHT-FLOOR_MARGIN-H_SIZE, y_next >= FLOOR_Y SHALL set y=FLOOR_Y, vel=0, state DEAD.
REQ-026 i_hit high in FLY SHALL move to DEAD next cycle, vel=0, y frozen; i_hit wins over a same-cycle flap.
REQ-027 DEAD: y, vel frozen, ticks ignored; flap event -> READY with y=IY, vel=0, cooldown=0.
REQ-028 i_hit SHALL be ignored in READY and DEAD.
REQ-029 All state, position, velocity updates SHALL be registered; edge outputs combinational from y and constant IX.

Reset
REQ-030 On i_rst: y=IY, vel=0, state READY, o_dead=0, cooldown=0; reset overrides all other inputs that cycle.
REQ-031 Previous-flap register SHALL reset to 1 so a button held through reset does not start flight until released and pressed again.

Verification
REQ-032 Reset, pulse i_flap -> FLY, vel=-10, y=240; next tick y=230, vel=-9.
REQ-033 From vel=0 in FLY, 14 ticks no flap -> vel reaches 12 after 12 ticks, stays 12.
REQ-034 Fall to floor -> y=442, o_dead=1, o_state=10; further ticks leave y=442.
REQ-035 y=12, vel=-10, tick -> y=8, vel=0, o_state=01.
REQ-036 Flap, then second flap edge 2 ticks later -> second ignored, vel=-8; flap after 4 ticks -> vel=-10.
REQ-037 i_hit and flap same cycle in FLY -> DEAD; flap edge -> READY, y=240; reset mid-flight with i_flap held -> READY, no start until release and re-press.
